// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM states and the iteration-counter width helper.
package muldiv_pkg;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      RUN,
      FIX,
      DONE_S
   } state_t;

   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int MD_WIDTH = 32;
   localparam int MD_CNT_W = cnt_w(MD_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply or restoring-divide step
// on a {upper, lower} accumulator, purely combinational.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   acc_in,
   input  logic [WIDTH-1:0]     mag,
   output logic [2*WIDTH-1:0]   acc_out
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   // trial never exceeds 2*mag-1, so diff[WIDTH] is a clean borrow flag.
   always_comb begin
      sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, mag};
      trial   = acc_in[2*WIDTH-1:WIDTH-1];
      diff    = trial - {1'b0, mag};
      acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
      if (is_div) begin
         if (!diff[WIDTH]) begin
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
         end else begin
            acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
         end
      end else if (acc_in[0]) begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// HI/LO register owner running MULT/MULTU/DIV/DIVU one bit per clock.
// Optional macro HILO_ZERO_SKIP_EN: skip the iterations when either operand is zero.
module hilo_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [1:0]        OP,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic              HI_WE,
   input  logic              LO_WE,
   input  logic [WIDTH-1:0]  WDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic [WIDTH-1:0]  HI,
   output logic [WIDTH-1:0]  LO
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0]     mag_q, mag_d;
   logic                 sa_q, sa_d, sb_q, sb_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

   logic                 is_div, is_signed;
   logic [WIDTH-1:0]     mag_a, mag_b, quo, rem;
   logic [2*WIDTH-1:0]   prod, step_acc;

   assign is_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);
   assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc_in  (acc_q),
      .mag     (mag_q),
      .acc_out (step_acc)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      mag_d   = mag_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
      mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
      prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo   = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem   = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      case (state_q)
         IDLE: begin
            if (HI_WE) hi_d = WDATA;
            if (LO_WE) lo_d = WDATA;
            if (START) begin
               state_d = PREP;
               op_d    = OP;
               a_d     = A;
               b_d     = B;
            end
         end
         // Upper half starts cleared; the multiplier/dividend rides in the lower half.
         PREP: begin
            sa_d    = is_signed && a_q[WIDTH-1];
            sb_d    = is_signed && b_q[WIDTH-1];
            mag_d   = is_div ? mag_b : mag_a;
            acc_d   = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
            cnt_d   = '0;
            state_d = RUN;
`ifdef HILO_ZERO_SKIP_EN
            if ((a_q == '0) || (b_q == '0)) begin
               acc_d   = '0;
               state_d = FIX;
            end
`endif
         end
         RUN: begin
            acc_d = step_acc;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = FIX;
            end
         end
         FIX: begin
            if (is_div && (b_q == '0)) begin
               hi_d = a_q;
               lo_d = '1;
            end else if (is_div) begin
               hi_d = rem;
               lo_d = quo;
            end else begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            state_d = DONE_S;
         end
         DONE_S: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mag_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         mag_q   <= mag_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign BUSY = (state_q != IDLE);
   assign DONE = (state_q == DONE_S);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: doc/hilo_muldiv_seq.md
Name: hilo_muldiv_seq

Overview:
Multi-cycle sequencer for the HI/LO special registers of the MIPS core. It executes MULT/MULTU/DIV/DIVU iteratively with one shift-add or shift-subtract per clock and owns the HI/LO storage. It also services MTHI/MTLO writes. It sits beside the single-cycle datapath, and the control unit stalls on BUSY. MFHI/MFLO read the HI/LO outputs directly.

Parameters:
WIDTH, 32, operand and HI/LO width; iteration count = WIDTH.

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous reset, active-high
START  input  1  request an operation; sampled only in IDLE
OP  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
A  input  WIDTH  rs operand (multiplicand / dividend)
B  input  WIDTH  rt operand (multiplier / divisor)
HI_WE  input  1  MTHI write strobe
LO_WE  input  1  MTLO write strobe
WDATA  input  WIDTH  MTHI/MTLO data
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse; HI/LO hold the new result
HI  output  WIDTH  HI register (remainder / product upper half)
LO  output  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset, checked on the CLK edge with RST=1: state IDLE; HI=0; LO=0; BUSY=0; DONE=0; counter=0; internal accumulators=0. RST overrides START, HI_WE and LO_WE.
- FSM states and transitions:
  - IDLE to PREP on START.
  - PREP to RUN.
  - RUN to FIX after WIDTH iterations, when the counter reaches WIDTH-1.
  - FIX to DONE_S.
  - DONE_S to IDLE.
- PREP: latch OP and the operand sign flags. Form operand magnitudes; unsigned OPs use operands as-is. Clear the 2*WIDTH accumulator.
- RUN, multiply: shift-add on the multiplier LSB.
- RUN, divide: restoring divide; shift remainder left, trial subtract, set quotient bit.
- FIX, MULT: negate the 2*WIDTH product if sign(A) differs from sign(B).
- FIX, DIV: negate the quotient if the signs differ; the remainder takes the sign of A.
- FIX writes HI/LO on the edge leaving FIX.
- Latency: START accepted at edge E0; DONE=1 for exactly the one cycle following edge E(WIDTH+2), i.e. 34 edges for WIDTH=32. The state returns to IDLE on the next edge.
- START with BUSY=1 is ignored: no queueing, no error.
- Operands are sampled only at acceptance; later changes to A and B have no effect.
- Divide by zero (B=0, DIVU or DIV): HI=A and LO=all ones, regardless of signedness. Same latency as a normal divide unless the optional feature is enabled.
- Signed corner case: DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- Arithmetic is modulo 2^WIDTH per half; no overflow flag.
- MTHI/MTLO in IDLE: HI_WE (or LO_WE) loads WDATA into HI (or LO) on that edge. Both strobes together load both registers.
- HI_WE/LO_WE while BUSY=1 are ignored. HI/LO stay stable during an operation until the FIX edge.
- START together with HI_WE/LO_WE in IDLE: the MT write takes effect, then the operation starts. The final result overwrites HI/LO.
- RST mid-operation: the operation is aborted and DONE is not pulsed. HI/LO are cleared to 0.

Optional Feature:
HILO_ZERO_SKIP_EN.
- Defined: in PREP, if A=0 or B=0, jump directly to FIX. DONE then follows edge E2, and results are identical to the full run (product 0; divide-by-zero result as above).
- Undefined: every operation takes the full WIDTH iterations.

Decomposition:
- Package muldiv_pkg:
  - OP codes: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV.
  - FSM state enum: IDLE, PREP, RUN, FIX, DONE_S.
  - Counter width constant: clog2(WIDTH).
- Sub-module muldiv_step: combinational single iteration taking op-is-div, accumulator and operand magnitude, and returning the next accumulator. The FSM, counter and HI/LO registers stay in the top module.

Test Plan:
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF, START at E0 -> DONE after E34; HI=0xFFFFFFFE, LO=0x00000001; BUSY=1 from E0 through the DONE cycle.
- MULT with A=-3 (0xFFFFFFFD), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV with A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU with A=100, B=0 -> HI=0x00000064, LO=0xFFFFFFFF. With HILO_ZERO_SKIP_EN defined, DONE follows E2.
- DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- While BUSY: pulse START with new operands and HI_WE with WDATA=0x12345678 -> both ignored; the original result lands, and the MTHI value never appears.
- RST for one edge at E10 of a MULTU -> state IDLE, HI=LO=0, no DONE pulse. A new START immediately afterwards completes normally.
